hls_bridge_buffered: RTL and testbench
======================================

Name: hls_bridge_buffered

Overview:
- Parametrised successor to the CPU-bus-to-HLS stream bridge.
- Registers and buffers the command path in a 2-entry skid buffer, so io_bus_cmd_ready has no combinational path from the HLS FIFO full flags.
- Packs all command fields into one HLS command stream and unpacks one HLS response stream.
- Tracks outstanding reads against a credit limit, translates addresses under parameter control, and flags misaligned and orphan traffic with sticky error bits.

Parameters:
- DATA_WIDTH, 32: bus data width; multiple of 8.
- DATA_ADDR_WIDTH, 32: bus address width and HLS address field width.
- ADDR_SHIFT, 2: byte-to-word shift applied to the address.
- ADDR_DROP_MSBS, 1: number of address MSBs cleared before the shift (linker region bits).
- MAX_OUTSTANDING, 4: maximum read commands awaiting a last response beat; must be 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- io_bus_cmd_valid  in  1  command valid
- io_bus_cmd_ready  out  1  command accept
- io_bus_cmd_payload_address  in  DATA_ADDR_WIDTH  byte address
- io_bus_cmd_payload_data  in  DATA_WIDTH  write data
- io_bus_cmd_payload_mask  in  DATA_WIDTH/8  byte enables
- io_bus_cmd_payload_write  in  1  1=write, 0=read
- io_bus_cmd_payload_uncached  in  1  passthrough
- io_bus_cmd_payload_size  in  3  passthrough
- io_bus_cmd_payload_last  in  1  passthrough
- io_bus_rsp_valid  out  1  response beat valid; the bus has no backpressure
- io_bus_rsp_payload_data  out  DATA_WIDTH  response data
- io_bus_rsp_payload_last  out  1  last beat of a read response
- hls_cmd_din  out  CMD_W  packed command; CMD_W = DATA_ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH/8 + 6
- hls_cmd_full_n  in  1  HLS command FIFO not full
- hls_cmd_write  out  1  HLS command FIFO push
- hls_rsp_dout  in  DATA_WIDTH+1  packed response {last, data}
- hls_rsp_empty_n  in  1  HLS response FIFO not empty
- hls_rsp_read  out  1  HLS response FIFO pop
- outstanding  out  8  current read credit count
- misalign_err  out  1  sticky: an accepted address had nonzero low ADDR_SHIFT bits
- orphan_err  out  1  sticky: a response beat arrived with no read outstanding

Behaviour:
- Reset:
  - Skid buffer is emptied; outstanding = 0.
  - io_bus_rsp_valid, hls_cmd_write, hls_rsp_read, misalign_err and orphan_err are all 0.
  - io_bus_cmd_ready = 0 while rst = 1.
  - Reset asserted mid-operation discards buffered commands and any in-flight response register contents.
- Packing:
  - hls_cmd_din = {last, size, uncached, write, mask, data, addr_xlat}, with addr_xlat in the LSBs.
  - addr_xlat = (address with its top ADDR_DROP_MSBS bits cleared) >> ADDR_SHIFT, zero-extended.
- Accept:
  - io_bus_cmd_ready = !rst && buf_count < 2 && (outstanding + buffered_reads) < MAX_OUTSTANDING.
  - ready is a function of registers only.
  - accept = io_bus_cmd_valid && io_bus_cmd_ready.
  - Writes are subject to the same credit gate, which keeps bus ordering.
- Issue:
  - hls_cmd_write = buf_count > 0 && hls_cmd_full_n.
  - Buffer head pops in the same cycle as hls_cmd_write.
  - Buffer is FIFO-ordered. Accept and pop may occur in the same cycle.
  - Latency: a command accepted in cycle N reaches hls_cmd_write no earlier than cycle N+1.
  - Credit: outstanding increments when a read command (write = 0) pops to HLS. Writes never consume credit and get no response.
- Response:
  - hls_rsp_read = !rst && hls_rsp_empty_n, i.e. always drain the response FIFO.
  - On the cycle after a pop, io_bus_rsp_valid = 1, with data and last registered from hls_rsp_dout. Otherwise io_bus_rsp_valid = 0.
  - A popped beat with last = 1 decrements outstanding.
  - An increment and decrement in the same cycle leave outstanding unchanged.
  - If a beat is popped while outstanding = 0 and no increment occurs that cycle: drop the beat (io_bus_rsp_valid stays 0) and set orphan_err.
- Errors: misalign_err is set on accept when address[ADDR_SHIFT-1:0] != 0; the command is still forwarded. Both error flags clear only on rst.
- Full, saturation and wrap-around:
  - With hls_cmd_full_n = 0 the buffer fills to 2 entries, then ready drops. No command is lost or duplicated.
  - outstanding never exceeds MAX_OUTSTANDING and never wraps below 0.

Decomposition:
- Package hls_bridge_pkg holds:
  - cmd_width(DATA_WIDTH, ADDR_WIDTH) function;
  - field offset constants for packing and unpacking;
  - the rsp last-bit position.
- One sub-module: hls_bridge_skid, a generic 2-entry valid/ready buffer parametrised by width and exposing its count.

Test Plan:
- Read at 0x8000_0010 with defaults → hls_cmd_din addr field = 0x0000_0004, write = 0, outstanding = 1. Then rsp {1, 0xDEADBEEF} → io_bus_rsp_valid one cycle later with data 0xDEADBEEF, last = 1, outstanding = 0.
- Hold hls_cmd_full_n = 0, offer 3 writes → exactly 2 accepted and ready = 0. Release full_n → 2 pushes in order, then the 3rd is accepted and pushed.
- MAX_OUTSTANDING = 4, issue 5 reads with no responses → 4 accepted, ready low for the 5th. One last beat → 5th accepted.
- Response beat while outstanding = 0 → no io_bus_rsp_valid, orphan_err = 1 until rst.
- Read at address 0x0000_0006 → misalign_err = 1, addr field = 0x1.
- Assert rst with 2 buffered commands and outstanding = 3 → next cycle buffer empty, outstanding = 0, no hls_cmd_write, errors cleared.

Source files
------------

// File: rtl/hls_bridge_pkg.sv
// Shared constants and packing helpers for the buffered CPU-bus-to-HLS stream bridge.
package hls_bridge_pkg;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_kind_e;

  localparam int unsigned CMD_CTRL_BITS = 6;
  localparam int unsigned SIZE_BITS     = 3;

  function automatic int unsigned cmd_width(input int unsigned dw, input int unsigned aw);
    return aw + dw + dw / 8 + CMD_CTRL_BITS;
  endfunction

  // Command layout from LSB: addr | data | mask | write | uncached | size[2:0] | last
  function automatic int unsigned off_data(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned off_mask(input int unsigned dw, input int unsigned aw);
    return aw + dw;
  endfunction

  function automatic int unsigned off_write(input int unsigned dw, input int unsigned aw);
    return aw + dw + dw / 8;
  endfunction

  function automatic int unsigned off_uncached(input int unsigned dw, input int unsigned aw);
    return off_write(dw, aw) + 1;
  endfunction

  function automatic int unsigned off_size(input int unsigned dw, input int unsigned aw);
    return off_write(dw, aw) + 2;
  endfunction

  function automatic int unsigned off_last(input int unsigned dw, input int unsigned aw);
    return off_write(dw, aw) + 2 + SIZE_BITS;
  endfunction

  // Response stream is {last, data}
  function automatic int unsigned rsp_last_pos(input int unsigned dw);
    return dw;
  endfunction

endpackage

// File: rtl/hls_bridge_buffered_if.sv
// CPU-side command/response bus of the buffered HLS bridge.
interface hls_bridge_buffered_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_ADDR_WIDTH = 32
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [DATA_ADDR_WIDTH-1:0]   cmd_payload_address;
  logic [DATA_WIDTH-1:0]        cmd_payload_data;
  logic [DATA_WIDTH/8-1:0]      cmd_payload_mask;
  logic                         cmd_payload_write;
  logic                         cmd_payload_uncached;
  logic [2:0]                   cmd_payload_size;
  logic                         cmd_payload_last;
  logic                         rsp_valid;
  logic [DATA_WIDTH-1:0]        rsp_payload_data;
  logic                         rsp_payload_last;

  modport master (
    output cmd_valid, cmd_payload_address, cmd_payload_data, cmd_payload_mask,
           cmd_payload_write, cmd_payload_uncached, cmd_payload_size, cmd_payload_last,
    input  cmd_ready, rsp_valid, rsp_payload_data, rsp_payload_last
  );

  modport slave (
    input  cmd_valid, cmd_payload_address, cmd_payload_data, cmd_payload_mask,
           cmd_payload_write, cmd_payload_uncached, cmd_payload_size, cmd_payload_last,
    output cmd_ready, rsp_valid, rsp_payload_data, rsp_payload_last
  );
endinterface

// File: rtl/hls_bridge_skid.sv
// Generic 2-entry FIFO-ordered valid/ready buffer; push and pop may share a cycle.
module hls_bridge_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] slot_q [2];
  logic [1:0]       count_q, count_d;
  logic             push, pop, wr_idx;

  always_comb begin
    pop     = out_ready_i && (count_q != 2'd0);
    push    = in_valid_i && (count_q != 2'd2);
    // Head sits in slot 0; a push lands behind whatever survives this cycle's pop
    wr_idx  = (count_q == 2'd1) && !pop;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int unsigned i = 0; i < 2; i++) slot_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (pop) slot_q[0] <= slot_q[1];
      if (push) slot_q[wr_idx] <= in_data_i;
    end
  end

  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = slot_q[0];
  assign count_o     = count_q;

endmodule

// File: rtl/hls_bridge_buffered.sv
// CPU-bus-to-HLS stream bridge with a registered 2-entry command buffer, read credits
// and sticky misalign/orphan error flags.
module hls_bridge_buffered
  import hls_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_ADDR_WIDTH = 32,
  parameter int unsigned ADDR_SHIFT      = 2,
  parameter int unsigned ADDR_DROP_MSBS  = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CMD_W = cmd_width(DATA_WIDTH, DATA_ADDR_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  hls_bridge_buffered_if.slave   io_bus,
  output logic [CMD_W-1:0]       hls_cmd_din,
  input  logic                   hls_cmd_full_n,
  output logic                   hls_cmd_write,
  input  logic [DATA_WIDTH:0]    hls_rsp_dout,
  input  logic                   hls_rsp_empty_n,
  output logic                   hls_rsp_read,
  output logic [7:0]             outstanding,
  output logic                   misalign_err,
  output logic                   orphan_err
);

  localparam int unsigned OFF_DATA     = off_data(DATA_ADDR_WIDTH);
  localparam int unsigned OFF_MASK     = off_mask(DATA_WIDTH, DATA_ADDR_WIDTH);
  localparam int unsigned OFF_WRITE    = off_write(DATA_WIDTH, DATA_ADDR_WIDTH);
  localparam int unsigned OFF_UNCACHED = off_uncached(DATA_WIDTH, DATA_ADDR_WIDTH);
  localparam int unsigned OFF_SIZE     = off_size(DATA_WIDTH, DATA_ADDR_WIDTH);
  localparam int unsigned OFF_LAST     = off_last(DATA_WIDTH, DATA_ADDR_WIDTH);
  localparam int unsigned RSP_LAST     = rsp_last_pos(DATA_WIDTH);

  localparam logic [DATA_ADDR_WIDTH-1:0] KEEP_MASK = {DATA_ADDR_WIDTH{1'b1}} >> ADDR_DROP_MSBS;
  localparam logic [DATA_ADDR_WIDTH-1:0] LOW_MASK  =
    DATA_ADDR_WIDTH'((64'd1 << ADDR_SHIFT) - 64'd1);

  logic [7:0]            out_q, out_d;
  logic [1:0]            rd_buf_q, rd_buf_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  misalign_q, misalign_d;
  logic                  orphan_q, orphan_d;

  logic [DATA_ADDR_WIDTH-1:0] addr_xlat;
  logic [CMD_W-1:0]           cmd_pack;
  logic [CMD_W-1:0]           skid_head;
  logic                       skid_valid;
  logic [1:0]                 buf_count;
  logic [9:0]                 credit_sum;
  logic                       credit_ok, cmd_ready, accept, accept_read;
  logic                       issue, head_is_read, inc, dec;
  logic                       rsp_pop, rsp_orphan;

  always_comb begin
    addr_xlat = (io_bus.cmd_payload_address & KEEP_MASK) >> ADDR_SHIFT;
    cmd_pack  = '0;
    cmd_pack[0 +: DATA_ADDR_WIDTH]      = addr_xlat;
    cmd_pack[OFF_DATA +: DATA_WIDTH]    = io_bus.cmd_payload_data;
    cmd_pack[OFF_MASK +: DATA_WIDTH/8]  = io_bus.cmd_payload_mask;
    cmd_pack[OFF_WRITE]                 = io_bus.cmd_payload_write;
    cmd_pack[OFF_UNCACHED]              = io_bus.cmd_payload_uncached;
    cmd_pack[OFF_SIZE +: SIZE_BITS]     = io_bus.cmd_payload_size;
    cmd_pack[OFF_LAST]                  = io_bus.cmd_payload_last;
  end

  // Reads still sitting in the buffer count against the credit limit so that
  // ready never depends on the HLS full flag combinationally.
  always_comb begin
    credit_sum   = 10'(out_q) + 10'(rd_buf_q);
    credit_ok    = credit_sum < 10'(MAX_OUTSTANDING);
    cmd_ready    = !rst && (buf_count < 2'd2) && credit_ok;
    accept       = io_bus.cmd_valid && cmd_ready;
    accept_read  = accept && (cmd_kind_e'(io_bus.cmd_payload_write) == CMD_READ);
    issue        = !rst && skid_valid && hls_cmd_full_n;
    head_is_read = cmd_kind_e'(skid_head[OFF_WRITE]) == CMD_READ;
    inc          = issue && head_is_read;
    rsp_pop      = !rst && hls_rsp_empty_n;
    rsp_orphan   = rsp_pop && (out_q == 8'd0) && !inc;
    dec          = rsp_pop && hls_rsp_dout[RSP_LAST] && !rsp_orphan;
  end

  always_comb begin
    out_d       = out_q + {7'd0, inc} - {7'd0, dec};
    rd_buf_d    = rd_buf_q + {1'b0, accept_read} - {1'b0, inc};
    rsp_valid_d = rsp_pop && !rsp_orphan;
    rsp_data_d  = rsp_valid_d ? hls_rsp_dout[DATA_WIDTH-1:0] : rsp_data_q;
    rsp_last_d  = rsp_valid_d ? hls_rsp_dout[RSP_LAST] : rsp_last_q;
    misalign_d  = misalign_q || (accept && ((io_bus.cmd_payload_address & LOW_MASK) != '0));
    orphan_d    = orphan_q || rsp_orphan;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      rd_buf_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      misalign_q  <= 1'b0;
      orphan_q    <= 1'b0;
    end else begin
      out_q       <= out_d;
      rd_buf_q    <= rd_buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      misalign_q  <= misalign_d;
      orphan_q    <= orphan_d;
    end
  end

  hls_bridge_skid #(
    .WIDTH(CMD_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (accept),
    .in_data_i   (cmd_pack),
    .out_valid_o (skid_valid),
    .out_ready_i (issue),
    .out_data_o  (skid_head),
    .count_o     (buf_count)
  );

  assign io_bus.cmd_ready        = cmd_ready;
  assign io_bus.rsp_valid        = rsp_valid_q;
  assign io_bus.rsp_payload_data = rsp_data_q;
  assign io_bus.rsp_payload_last = rsp_last_q;
  assign hls_cmd_din             = skid_head;
  assign hls_cmd_write           = issue;
  assign hls_rsp_read            = rsp_pop;
  assign outstanding             = out_q;
  assign misalign_err            = misalign_q;
  assign orphan_err              = orphan_q;

endmodule

// File: tb/tb_hls_bridge_buffered.sv
// Directed self-checking bench for hls_bridge_buffered with default parameters.
module tb_hls_bridge_buffered;

  logic        clk;
  logic        rst;
  logic [73:0] hls_cmd_din;
  logic        hls_cmd_full_n;
  logic        hls_cmd_write;
  logic [32:0] hls_rsp_dout;
  logic        hls_rsp_empty_n;
  logic        hls_rsp_read;
  logic [7:0]  outstanding;
  logic        misalign_err;
  logic        orphan_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  hls_bridge_buffered_if #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32)) bus ();

  hls_bridge_buffered #(
    .DATA_WIDTH      (32),
    .DATA_ADDR_WIDTH (32),
    .ADDR_SHIFT      (2),
    .ADDR_DROP_MSBS  (1),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .io_bus          (bus),
    .hls_cmd_din     (hls_cmd_din),
    .hls_cmd_full_n  (hls_cmd_full_n),
    .hls_cmd_write   (hls_cmd_write),
    .hls_rsp_dout    (hls_rsp_dout),
    .hls_rsp_empty_n (hls_rsp_empty_n),
    .hls_rsp_read    (hls_rsp_read),
    .outstanding     (outstanding),
    .misalign_err    (misalign_err),
    .orphan_err      (orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [31:0] addr, input logic wr, input logic [31:0] data);
    bus.cmd_valid            = 1'b1;
    bus.cmd_payload_address  = addr;
    bus.cmd_payload_write    = wr;
    bus.cmd_payload_data     = data;
    bus.cmd_payload_mask     = 4'hF;
    bus.cmd_payload_uncached = 1'b1;
    bus.cmd_payload_size     = 3'b010;
    bus.cmd_payload_last     = 1'b1;
  endtask

  task automatic do_read(input logic [31:0] addr);
    drive_cmd(addr, 1'b0, 32'h0);
    step();
    bus.cmd_valid = 1'b0;
    step();
  endtask

  int unsigned accepts;
  int unsigned pushes;

  initial begin
    rst             = 1'b1;
    hls_cmd_full_n  = 1'b1;
    hls_rsp_empty_n = 1'b1;
    hls_rsp_dout    = '0;
    drive_cmd(32'h0, 1'b0, 32'h0);
    bus.cmd_valid   = 1'b0;

    // Reset state
    step();
    step();
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_rsp_read", 64'(hls_rsp_read), 64'd0);
    check("rst_cmd_write", 64'(hls_cmd_write), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_errs", 64'({misalign_err, orphan_err}), 64'd0);
    rst             = 1'b0;
    hls_rsp_empty_n = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.cmd_ready), 64'd1);

    // Read at 0x8000_0010, then a last response beat
    drive_cmd(32'h8000_0010, 1'b0, 32'h1234_5678);
    #1;
    check("t1_no_early_push", 64'(hls_cmd_write), 64'd0);
    step();
    bus.cmd_valid = 1'b0;
    #1;
    check("t1_push", 64'(hls_cmd_write), 64'd1);
    check("t1_addr", 64'(hls_cmd_din[31:0]), 64'h4);
    check("t1_ctrl", 64'(hls_cmd_din[73:68]), 64'h2A);
    check("t1_mask_data", 64'(hls_cmd_din[67:32]), 64'hF_1234_5678);
    check("t1_out_before", 64'(outstanding), 64'd0);
    step();
    check("t1_out_inc", 64'(outstanding), 64'd1);
    check("t1_push_done", 64'(hls_cmd_write), 64'd0);
    hls_rsp_empty_n = 1'b1;
    hls_rsp_dout    = {1'b1, 32'hDEAD_BEEF};
    #1;
    check("t1_rsp_read", 64'(hls_rsp_read), 64'd1);
    check("t1_rsp_not_yet", 64'(bus.rsp_valid), 64'd0);
    step();
    hls_rsp_empty_n = 1'b0;
    #1;
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t1_rsp_data", 64'(bus.rsp_payload_data), 64'hDEAD_BEEF);
    check("t1_rsp_last", 64'(bus.rsp_payload_last), 64'd1);
    check("t1_out_dec", 64'(outstanding), 64'd0);
    step();
    check("t1_rsp_one_cycle", 64'(bus.rsp_valid), 64'd0);

    // Full HLS FIFO: exactly two writes buffered, then ordered drain
    hls_cmd_full_n = 1'b0;
    drive_cmd(32'h200, 1'b1, 32'hAAAA_0001);
    #1;
    check("t2_ready_a", 64'(bus.cmd_ready), 64'd1);
    step();
    drive_cmd(32'h204, 1'b1, 32'hAAAA_0002);
    #1;
    check("t2_ready_b", 64'(bus.cmd_ready), 64'd1);
    step();
    drive_cmd(32'h208, 1'b1, 32'hAAAA_0003);
    #1;
    check("t2_ready_full", 64'(bus.cmd_ready), 64'd0);
    check("t2_no_push", 64'(hls_cmd_write), 64'd0);
    step();
    check("t2_ready_held", 64'(bus.cmd_ready), 64'd0);
    hls_cmd_full_n = 1'b1;
    #1;
    check("t2_push_a", 64'(hls_cmd_write), 64'd1);
    check("t2_data_a", 64'(hls_cmd_din[63:32]), 64'hAAAA_0001);
    step();
    check("t2_ready_c", 64'(bus.cmd_ready), 64'd1);
    check("t2_push_b", 64'(hls_cmd_write), 64'd1);
    check("t2_data_b", 64'(hls_cmd_din[63:32]), 64'hAAAA_0002);
    step();
    bus.cmd_valid = 1'b0;
    #1;
    check("t2_push_c", 64'(hls_cmd_write), 64'd1);
    check("t2_data_c", 64'(hls_cmd_din[63:32]), 64'hAAAA_0003);
    check("t2_wr_bit", 64'(hls_cmd_din[68]), 64'd1);
    check("t2_addr_c", 64'(hls_cmd_din[31:0]), 64'h82);
    step();
    check("t2_drained", 64'(hls_cmd_write), 64'd0);
    check("t2_no_credit", 64'(outstanding), 64'd0);

    // Credit limit: 5 reads offered, 4 taken
    accepts = 0;
    pushes  = 0;
    drive_cmd(32'h100, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.cmd_ready) accepts++;
      if (hls_cmd_write) pushes++;
      step();
    end
    check("t3_accepts", 64'(accepts), 64'd4);
    check("t3_pushes", 64'(pushes), 64'd4);
    check("t3_out_sat", 64'(outstanding), 64'd4);
    check("t3_ready_low", 64'(bus.cmd_ready), 64'd0);
    hls_rsp_empty_n = 1'b1;
    hls_rsp_dout    = {1'b1, 32'h0000_1111};
    step();
    hls_rsp_empty_n = 1'b0;
    #1;
    check("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t3_out_3", 64'(outstanding), 64'd3);
    check("t3_ready_back", 64'(bus.cmd_ready), 64'd1);
    step();
    bus.cmd_valid = 1'b0;
    #1;
    check("t3_fifth_push", 64'(hls_cmd_write), 64'd1);
    step();
    check("t3_out_4", 64'(outstanding), 64'd4);
    hls_rsp_empty_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    hls_rsp_empty_n = 1'b0;
    #1;
    check("t3_out_drained", 64'(outstanding), 64'd0);
    check("t3_no_orphan", 64'(orphan_err), 64'd0);

    // Orphan beat
    step();
    hls_rsp_empty_n = 1'b1;
    hls_rsp_dout    = {1'b0, 32'h0000_0BAD};
    step();
    hls_rsp_empty_n = 1'b0;
    #1;
    check("t4_dropped", 64'(bus.rsp_valid), 64'd0);
    check("t4_orphan", 64'(orphan_err), 64'd1);
    check("t4_out_floor", 64'(outstanding), 64'd0);
    step();
    step();
    check("t4_orphan_sticky", 64'(orphan_err), 64'd1);

    // Misaligned read
    drive_cmd(32'h0000_0006, 1'b0, 32'h0);
    #1;
    check("t5_no_err_yet", 64'(misalign_err), 64'd0);
    step();
    bus.cmd_valid = 1'b0;
    #1;
    check("t5_misalign", 64'(misalign_err), 64'd1);
    check("t5_push", 64'(hls_cmd_write), 64'd1);
    check("t5_addr", 64'(hls_cmd_din[31:0]), 64'h1);
    step();
    check("t5_out", 64'(outstanding), 64'd1);
    hls_rsp_empty_n = 1'b1;
    hls_rsp_dout    = {1'b1, 32'h0000_0055};
    step();
    hls_rsp_empty_n = 1'b0;
    #1;
    check("t5_rsp_data", 64'(bus.rsp_payload_data), 64'h55);
    check("t5_out_0", 64'(outstanding), 64'd0);

    // Reset mid-operation: 3 reads outstanding, 2 writes buffered
    do_read(32'h300);
    do_read(32'h304);
    do_read(32'h308);
    check("t6_out_3", 64'(outstanding), 64'd3);
    hls_cmd_full_n = 1'b0;
    drive_cmd(32'h400, 1'b1, 32'hBBBB_0001);
    step();
    drive_cmd(32'h404, 1'b1, 32'hBBBB_0002);
    step();
    bus.cmd_valid = 1'b0;
    #1;
    check("t6_buf_full", 64'(bus.cmd_ready), 64'd0);
    rst             = 1'b1;
    hls_cmd_full_n  = 1'b1;
    hls_rsp_empty_n = 1'b1;
    hls_rsp_dout    = {1'b1, 32'hCCCC_CCCC};
    #1;
    check("t6_rst_no_push", 64'(hls_cmd_write), 64'd0);
    check("t6_rst_no_pop", 64'(hls_rsp_read), 64'd0);
    step();
    rst             = 1'b0;
    hls_rsp_empty_n = 1'b0;
    #1;
    check("t6_buf_empty", 64'(hls_cmd_write), 64'd0);
    check("t6_out_clr", 64'(outstanding), 64'd0);
    check("t6_errs_clr", 64'({misalign_err, orphan_err}), 64'd0);
    check("t6_rsp_clr", 64'(bus.rsp_valid), 64'd0);
    check("t6_ready", 64'(bus.cmd_ready), 64'd1);
    step();
    check("t6_still_empty", 64'(hls_cmd_write), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
